// File: rtl/vowel_pkg.sv
// Shared types and constants for the vowel eliminator / restorer pair.
package vowel_pkg;

    localparam int unsigned N_CHARS = 8;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned IDX_W   = $clog2(N_CHARS);

    typedef logic [CHAR_W-1:0]   char_t;
    typedef logic [N_CHARS-1:0]  mask_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef char_t [N_CHARS-1:0] word_t;

    // Compacted form of one word as produced by the eliminator.
    typedef struct packed {
        word_t cons;
        word_t vows;
        mask_t mask;
    } coded_word_t;

    typedef enum logic {IDLE, EMIT} state_t;

    localparam char_t CH_A = 8'h41;
    localparam char_t CH_E = 8'h45;
    localparam char_t CH_I = 8'h49;
    localparam char_t CH_O = 8'h4F;
    localparam char_t CH_U = 8'h55;

    function automatic logic is_vowel(input char_t c);
        return (c == CH_A) || (c == CH_E) || (c == CH_I) || (c == CH_O) || (c == CH_U);
    endfunction

endpackage

// File: rtl/vowel_restore_if.sv
// Capture and emit streams of the vowel restorer, plus the parallel result port.
interface vowel_restore_if;
    import vowel_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t cons;
    word_t vows;
    mask_t mask;
    logic  out_valid;
    logic  out_ready;
    char_t out_char;
    idx_t  out_idx;
    logic  out_last;
    logic  word_valid;
    word_t res;

    modport master (
        output in_valid, cons, vows, mask, out_ready,
        input  in_ready, out_valid, out_char, out_idx, out_last, word_valid, res
    );

    modport slave (
        input  in_valid, cons, vows, mask, out_ready,
        output in_ready, out_valid, out_char, out_idx, out_last, word_valid, res
    );

endinterface

// File: rtl/vowel_restore.sv
// Rebuilds a word from compacted consonants, compacted vowels and the vowel mask,
// streaming one character per beat and presenting the whole word on completion.
module vowel_restore
    import vowel_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    vowel_restore_if.slave bus
);

    state_t      state;
    coded_word_t word_r;
    idx_t        pos;
    idx_t        cp;
    idx_t        vp;

    idx_t        pos_nx;
    idx_t        cp_nx;
    idx_t        vp_nx;
    char_t       char_nx;
    char_t       char_first;

    // Pointers and character for the beat following the current one.
    always_comb begin
        pos_nx     = pos + IDX_W'(1);
        cp_nx      = cp;
        vp_nx      = vp;
        if (word_r.mask[pos]) begin
            vp_nx = vp + IDX_W'(1);
        end else begin
            cp_nx = cp + IDX_W'(1);
        end
        char_nx    = word_r.mask[pos_nx] ? word_r.vows[vp_nx] : word_r.cons[cp_nx];
        char_first = bus.mask[0] ? bus.vows[0] : bus.cons[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            word_r         <= '0;
            pos            <= '0;
            cp             <= '0;
            vp             <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_char   <= '0;
            bus.out_idx    <= '0;
            bus.out_last   <= 1'b0;
            bus.word_valid <= 1'b0;
            bus.res        <= '0;
        end else begin
            bus.word_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_r        <= '{cons: bus.cons, vows: bus.vows, mask: bus.mask};
                        pos           <= '0;
                        cp            <= '0;
                        vp            <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_char  <= char_first;
                        bus.out_idx   <= '0;
                        bus.out_last  <= 1'b0;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    // out_valid is always high here, so out_ready alone accepts a beat.
                    if (bus.out_ready) begin
                        bus.res[pos] <= bus.out_char;
                        pos          <= pos_nx;
                        cp           <= cp_nx;
                        vp           <= vp_nx;
                        if (bus.out_last) begin
                            state          <= IDLE;
                            bus.in_ready   <= 1'b1;
                            bus.out_valid  <= 1'b0;
                            bus.out_char   <= '0;
                            bus.out_idx    <= '0;
                            bus.out_last   <= 1'b0;
                            bus.word_valid <= 1'b1;
                        end else begin
                            bus.out_char <= char_nx;
                            bus.out_idx  <= pos_nx;
                            bus.out_last <= (pos_nx == IDX_W'(N_CHARS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vowel_restore.sv
// Randomised self-checking bench for vowel_restore against a queue-based reference.
module tb_vowel_restore;
    import vowel_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vowel_restore_if bus();

    vowel_restore dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    char_t got_char [N_CHARS];
    idx_t  got_idx  [N_CHARS];
    logic  got_last [N_CHARS];
    word_t got_word;
    int    loop_cyc;
    int    n_beats;
    bit    timed_out;
    int    unstable;
    int    wv_seen = 0;

    always @(negedge clk) if (bus.word_valid === 1'b1) wv_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic word_t str2word(input string s);
        word_t w;
        for (int i = 0; i < int'(N_CHARS); i++) w[i] = char_t'(s[i]);
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < int'(N_CHARS); i++) w[i] = char_t'($urandom);
        return w;
    endfunction

    function automatic word_t rand_az();
        word_t w;
        for (int i = 0; i < int'(N_CHARS); i++) w[i] = char_t'(8'h41 + $urandom_range(0, 25));
        return w;
    endfunction

    // Reference restore: pop from whichever compacted list the mask selects.
    function automatic word_t ref_restore(input word_t c, input word_t v, input mask_t m);
        char_t cq[$];
        char_t vq[$];
        word_t r;
        for (int i = 0; i < int'(N_CHARS); i++) begin
            cq.push_back(c[i]);
            vq.push_back(v[i]);
        end
        for (int i = 0; i < int'(N_CHARS); i++) r[i] = m[i] ? vq.pop_front() : cq.pop_front();
        return r;
    endfunction

    // Reference eliminator; unused tail entries are filled with junk.
    task automatic eliminate(input word_t w, output word_t c, output word_t v, output mask_t m);
        int nc = 0;
        int nv = 0;
        c = rand_word();
        v = rand_word();
        m = '0;
        for (int i = 0; i < int'(N_CHARS); i++) begin
            if (is_vowel(w[i])) begin
                m[i] = 1'b1; v[nv] = w[i]; nv++;
            end else begin
                c[nc] = w[i]; nc++;
            end
        end
    endtask

    task automatic start_word(input word_t c, input word_t v, input mask_t m);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        bus.cons = c; bus.vows = v; bus.mask = m; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cons = rand_word(); bus.vows = rand_word(); bus.mask = mask_t'($urandom);
    endtask

    // Drives out_ready and records accepted beats; returns at the negedge after stop_at beats.
    task automatic collect(input int stall_at, input int stall_n, input bit rnd,
                           input int pulse_at, input word_t pulse_word, input int stop_at);
        int    stalled = 0;
        bit    pulsed = 0;
        bit    prev_hold = 0;
        bit    rdy;
        char_t pc = '0;
        idx_t  pi = '0;
        logic  pl = 1'b0;
        loop_cyc = 0; n_beats = 0; timed_out = 0; unstable = 0; got_word = '0;
        while (n_beats < stop_at) begin
            if (loop_cyc >= 200) begin timed_out = 1; break; end
            loop_cyc++;
            if (n_beats == pulse_at && !pulsed) begin
                bus.in_valid = 1'b1; bus.cons = pulse_word; bus.vows = pulse_word;
                bus.mask = ~bus.mask; pulsed = 1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (prev_hold && (bus.out_char !== pc || bus.out_idx !== pi || bus.out_last !== pl))
                unstable++;
            if (n_beats == stall_at && stalled < stall_n) begin rdy = 0; stalled++; end
            else if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1;
            bus.out_ready = rdy;
            if (bus.out_valid === 1'b1 && rdy) begin
                got_char[n_beats] = bus.out_char;
                got_idx[n_beats]  = bus.out_idx;
                got_last[n_beats] = bus.out_last;
                got_word[n_beats] = bus.out_char;
                n_beats++;
                prev_hold = 0;
            end else begin
                prev_hold = (bus.out_valid === 1'b1);
                pc = bus.out_char; pi = bus.out_idx; pl = bus.out_last;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.cons = '0; bus.vows = '0; bus.mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_char !== '0 ||
            bus.out_idx !== '0 || bus.out_last !== 1'b0 || bus.word_valid !== 1'b0 || bus.res !== '0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b ov=%b ch=%h idx=%0d last=%b wv=%b res=%h required rdy=1 ov=0 rest 0",
                     bus.in_ready, bus.out_valid, bus.out_char, bus.out_idx, bus.out_last, bus.word_valid, bus.res);
        end
    endtask

    task automatic test_consonants();
        word_t c = str2word("BCDFGHJK");
        word_t v = rand_word();
        word_t exp = ref_restore(c, v, 8'h00);
        start_word(c, v, 8'h00);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (timed_out) begin bad++; $display("FAIL cons_timeout beats=%0d required=%0d", n_beats, N_CHARS); end
        for (int i = 0; i < n_beats; i++) begin
            total++;
            if (got_char[i] !== exp[i] || got_idx[i] !== idx_t'(i) || got_last[i] !== (i == N_CHARS - 1)) begin
                bad++;
                $display("FAIL cons_beat%0d got ch=%h idx=%0d last=%b required ch=%h idx=%0d last=%b",
                         i, got_char[i], got_idx[i], got_last[i], exp[i], i, (i == N_CHARS - 1));
            end
        end
        total++;
        if (bus.word_valid !== 1'b1 || bus.res !== exp || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL cons_word got wv=%b rdy=%b res=%h required wv=1 rdy=1 res=%h",
                     bus.word_valid, bus.in_ready, bus.res, exp);
        end
        total++;
        if (loop_cyc !== N_CHARS) begin bad++; $display("FAIL cons_cycles got %0d required %0d", loop_cyc, N_CHARS); end
        @(negedge clk);
        total++;
        if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL cons_strobe_width got wv=%b required 0", bus.word_valid); end
    endtask

    task automatic test_vowels();
        word_t c = rand_word();
        word_t v = str2word("AEIOUAEI");
        word_t exp = ref_restore(c, v, 8'hFF);
        start_word(c, v, 8'hFF);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (timed_out || got_word !== exp) begin
            bad++; $display("FAIL vows_beats got %h required %h (timeout=%0b)", got_word, exp, timed_out);
        end
        total++;
        if (bus.word_valid !== 1'b1 || bus.res !== exp) begin
            bad++; $display("FAIL vows_res got wv=%b res=%h required wv=1 res=%h", bus.word_valid, bus.res, exp);
        end
    endtask

    task automatic test_banana();
        word_t w = str2word("BANANAXY");
        word_t c, v;
        mask_t m;
        eliminate(w, c, v, m);
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (timed_out || got_word !== w) begin
            bad++; $display("FAIL banana_beats got %h required %h", got_word, w);
        end
        total++;
        if (got_last[N_CHARS-1] !== 1'b1 || got_last[N_CHARS-2] !== 1'b0) begin
            bad++; $display("FAIL banana_last got last7=%b last6=%b required 1 0", got_last[N_CHARS-1], got_last[N_CHARS-2]);
        end
        total++;
        if (bus.word_valid !== 1'b1 || bus.res !== w) begin
            bad++; $display("FAIL banana_res got wv=%b res=%h required wv=1 res=%h", bus.word_valid, bus.res, w);
        end
    endtask

    task automatic test_backpressure();
        word_t w = rand_az();
        word_t c, v;
        mask_t m;
        eliminate(w, c, v, m);
        start_word(c, v, m);
        collect(2, 3, 0, -1, '0, N_CHARS);
        total++;
        if (unstable != 0) begin bad++; $display("FAIL bp_stable got %0d changes required 0", unstable); end
        total++;
        if (got_word !== w) begin bad++; $display("FAIL bp_beats got %h required %h", got_word, w); end
        for (int i = 0; i < n_beats; i++) begin
            total++;
            if (got_idx[i] !== idx_t'(i)) begin bad++; $display("FAIL bp_idx%0d got %0d required %0d", i, got_idx[i], i); end
        end
        total++;
        if (loop_cyc + 1 != 12) begin bad++; $display("FAIL bp_cycles got %0d required 12", loop_cyc + 1); end
        total++;
        if (bus.word_valid !== 1'b1 || bus.res !== w) begin
            bad++; $display("FAIL bp_res got wv=%b res=%h required wv=1 res=%h", bus.word_valid, bus.res, w);
        end
    endtask

    task automatic test_ignore_in_valid();
        word_t wa = rand_az();
        word_t wb = rand_az();
        word_t c, v;
        mask_t m;
        eliminate(wa, c, v, m);
        start_word(c, v, m);
        collect(-1, 0, 0, 3, wb, N_CHARS);
        total++;
        if (got_word !== wa || bus.res !== wa || bus.word_valid !== 1'b1) begin
            bad++; $display("FAIL ign_word got beats=%h res=%h wv=%b required %h wv=1", got_word, bus.res, bus.word_valid, wa);
        end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL ign_no_capture got ov=%b rdy=%b required ov=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        eliminate(wb, c, v, m);
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (got_word !== wb || bus.res !== wb) begin
            bad++; $display("FAIL ign_next got beats=%h res=%h required %h", got_word, bus.res, wb);
        end
    endtask

    task automatic test_back_to_back();
        word_t w1 = rand_az();
        word_t w2 = rand_az();
        word_t c, v;
        mask_t m;
        time t1, t2;
        eliminate(w1, c, v, m);
        t1 = $time;
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        eliminate(w2, c, v, m);
        t2 = $time;
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (t2 - t1 != 90) begin bad++; $display("FAIL b2b_period got %0t required 90", t2 - t1); end
        total++;
        if (got_word !== w2 || bus.res !== w2 || loop_cyc != N_CHARS) begin
            bad++; $display("FAIL b2b_word2 got %h res=%h cyc=%0d required %h cyc=%0d", got_word, bus.res, loop_cyc, w2, N_CHARS);
        end
    endtask

    task automatic test_reset_mid();
        word_t w = rand_az();
        word_t c, v;
        mask_t m;
        int wv0;
        eliminate(w, c, v, m);
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, 4);
        wv0 = wv_seen;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== '0 || bus.res !== '0) begin
            bad++; $display("FAIL rstmid_async got ov=%b rdy=%b idx=%0d res=%h required ov=0 rdy=1 idx=0 res=0",
                            bus.out_valid, bus.in_ready, bus.out_idx, bus.res);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (wv_seen != wv0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet got strobes=%0d ov=%b required strobes=0 ov=0", wv_seen - wv0, bus.out_valid);
        end
        w = rand_az();
        eliminate(w, c, v, m);
        start_word(c, v, m);
        collect(-1, 0, 0, -1, '0, N_CHARS);
        total++;
        if (got_word !== w || bus.res !== w || got_idx[0] !== '0) begin
            bad++; $display("FAIL rstmid_fresh got %h res=%h idx0=%0d required %h idx0=0", got_word, bus.res, got_idx[0], w);
        end
    endtask

    task automatic test_random();
        word_t w, c, v;
        mask_t m;
        for (int n = 0; n < 1000; n++) begin
            w = rand_az();
            eliminate(w, c, v, m);
            start_word(c, v, m);
            collect(-1, 0, 1, -1, '0, N_CHARS);
            total++;
            if (timed_out || unstable != 0 || got_word !== w) begin
                bad++; $display("FAIL rand%0d_beats got %h required %h (timeout=%0b unstable=%0d)",
                                n, got_word, w, timed_out, unstable);
            end
            total++;
            if (bus.word_valid !== 1'b1 || bus.res !== w) begin
                bad++; $display("FAIL rand%0d_res got wv=%b res=%h required wv=1 res=%h", n, bus.word_valid, bus.res, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_consonants();
        test_vowels();
        test_banana();
        test_backpressure();
        test_ignore_in_valid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
